serial_shifter: RTL and testbench
=================================

# serial_shifter

Multi-cycle 16-bit shift/rotate unit for the opposite-direction shift ops: logical right, arithmetic left with overflow detect, and rotate left. It complements the single-cycle SLL/SRA/ROR shifter in the execute stage. A Start/Busy/Done handshake lets the pipeline stall on it. Operation takes one bit position per clock, so area stays small.

## Interface
- Parameters: none; width fixed at 16, shift amount 4 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only when not Busy
- Shift_In  input  16  operand, captured on the accepting edge
- Shift_val  input  4  shift amount N (0..15), captured on the accepting edge
- Mode  input  2  00 SRL, 01 SLA, 10 ROL, 11 ROL (alias)
- Busy  output  1  operation in progress; Start is ignored
- Done  output  1  one-cycle pulse; result valid
- Shift_Out  output  16  result; held until the next accepted Start
- Ovfl  output  1  SLA signed overflow; valid with Done, held with Shift_Out

## Operation
- States:
  - IDLE: accept when Start=1.
  - RUN: shifting.
  - DONE: Done=1 for one cycle. Accepts Start exactly like IDLE, allowing back-to-back operations.
- Accept edge (E0):
  - Load data register ← Shift_In, count ← Shift_val, mode register ← Mode, Ovfl ← 0.
  - N=0 → DONE. N>0 → RUN.
- Each RUN edge performs one step and decrements count:
  - SRL: {1'b0, d[15:1]}.
  - SLA: {d[14:0], 1'b0}. Ovfl sets (sticky) if d[15]≠d[14] before the step.
  - ROL: {d[14:0], d[15]}.
- The step that takes count to 0 → DONE. DONE → IDLE unless Start.
- Shift_Out is the data register, visible continuously. It is only meaningful from Done onward.
- Inputs changing during RUN have no effect.
- Ovfl stays 0 for SRL and ROL.
- SLA overflow meaning: Ovfl=1 iff Shift_In·2^N is not representable as a signed 16-bit value.

## Timing
- Reset (async, rst_n=0):
  - State IDLE.
  - Busy=0, Done=0, Shift_Out=16'h0000, Ovfl=0, count=0.
  - Takes effect immediately, including mid-RUN. The operation is aborted and no Done is issued.
- Latency: Done is high in the cycle following edge E_N, where E_0 is the accepting edge.
  - N=0 gives Done one cycle after Start.
- Busy: high for exactly N cycles (the RUN cycles); never high when N=0.
- Back-to-back: Start=1 during the Done cycle is accepted on that edge.
  - Done drops the next cycle.
  - Busy rises the next cycle if the new N>0.
- Start=1 while Busy: ignored, not queued.
- Done and Busy are never high together.

## Configuration
- SERSHIFT_DUAL_STEP_EN defined:
  - Each RUN edge shifts 2 positions while count≥2, else 1.
  - Busy lasts ceil(N/2) cycles; Done follows edge E_ceil(N/2).
  - SLA 2-bit step sets Ovfl if d[15], d[14], d[13] are not all equal.
  - Results are identical to single-step mode.
- Undefined: strictly 1 position per cycle, as described above.

## Structure
- Package shifter_pkg:
  - Mode constants MODE_SRL=2'b00, MODE_SLA=2'b01, MODE_ROL=2'b10.
  - State enum {IDLE, RUN, DONE}.
  - Shared with the combinational shifter's mode encoding where it overlaps.
- Sub-module serial_shift_step: purely combinational.
  - Inputs: d, mode, 1-or-2 step select.
  - Outputs: next d and step overflow.
  - Instantiated once.
- FSM, counter and registers live in serial_shifter.

## Test plan
- SRL: Shift_In=16'h8001, Shift_val=4, Mode=00 → Busy 4 cycles; Done after E4; Shift_Out=16'h0800; Ovfl=0.
- ROL:
  - 16'h8001, N=1, Mode=10 → 16'h0003.
  - 16'h1234, N=15, Mode=11 → 16'h091A.
- SLA:
  - 16'h4000, N=1 → 16'h8000, Ovfl=1.
  - 16'hFFF0, N=3 → 16'hFF80, Ovfl=0.
- Zero amount: 16'h1234, N=0 → no Busy; Done in the cycle after Start; Shift_Out=16'h1234.
- Handshake:
  - Start pulsed during Busy → ignored.
  - Start held through the Done cycle → second operation accepted back-to-back with its own correct result.
- Reset: rst_n low at cycle 2 of an N=8 op → Busy=0, Done=0, Shift_Out=0 immediately; no Done after release.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - mode encodings and FSM state type for the serial shift/rotate unit
package shifter_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    // Encodings line up with the execute-stage shifter where the ops overlap
    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SLA = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_step.sv
// rtl/serial_shift_step.sv - combinational one- or two-position SRL/SLA/ROL step with overflow flag
module serial_shift_step
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] i_d,
    input  logic [1:0]        i_mode,
    input  logic              i_dual,
    output logic [DATA_W-1:0] o_d,
    output logic              o_ovfl
);

    always_comb begin
        o_d    = i_d;
        o_ovfl = 1'b0;
        case (i_mode)
            MODE_SRL: o_d = i_dual ? {2'b00, i_d[15:2]} : {1'b0, i_d[15:1]};
            MODE_SLA: begin
                o_d = i_dual ? {i_d[13:0], 2'b00} : {i_d[14:0], 1'b0};
                // Any bit shifted past the sign that differs from the new sign is lost magnitude
                o_ovfl = i_dual ? !((i_d[15] == i_d[14]) && (i_d[14] == i_d[13]))
                                : (i_d[15] != i_d[14]);
            end
            default:  o_d = i_dual ? {i_d[13:0], i_d[15:14]} : {i_d[14:0], i_d[15]};
        endcase
    end

endmodule

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - multi-cycle 16-bit SRL/SLA/ROL unit with Start/Busy/Done; SERSHIFT_DUAL_STEP_EN enables 2-bit steps
module serial_shifter
    import shifter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [DATA_W-1:0] Shift_In,
    input  logic [CNT_W-1:0]  Shift_val,
    input  logic [1:0]        Mode,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Shift_Out,
    output logic              Ovfl
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_mode;
    logic              r_ovfl;

    logic              w_accept;
    logic              w_dual;
    logic [CNT_W-1:0]  w_step;
    logic              w_last;
    logic [DATA_W-1:0] w_data_next;
    logic              w_step_ovfl;

`ifdef SERSHIFT_DUAL_STEP_EN
    assign w_dual = (r_count >= 4'd2);
`else
    assign w_dual = 1'b0;
`endif

    assign w_step   = w_dual ? 4'd2 : 4'd1;
    assign w_last   = (r_count <= w_step);
    assign w_accept = Start && (r_state != RUN);

    serial_shift_step u_step (
        .i_d    (r_data),
        .i_mode (r_mode),
        .i_dual (w_dual),
        .o_d    (w_data_next),
        .o_ovfl (w_step_ovfl)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (Start) w_state_next = (Shift_val == '0) ? DONE : RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: w_state_next = Start ? ((Shift_val == '0) ? DONE : RUN) : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_mode  <= MODE_SRL;
            r_ovfl  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_data  <= Shift_In;
                r_count <= Shift_val;
                r_mode  <= Mode;
                r_ovfl  <= 1'b0;
            end else if (r_state == RUN) begin
                r_data  <= w_data_next;
                r_count <= w_last ? '0 : (r_count - w_step);
                r_ovfl  <= r_ovfl | w_step_ovfl;
            end
        end
    end

    assign Busy      = (r_state == RUN);
    assign Done      = (r_state == DONE);
    assign Shift_Out = r_data;
    assign Ovfl      = r_ovfl;

endmodule

// File: tb/tb_serial_shifter.sv
// tb/tb_serial_shifter.sv - directed self-checking bench for serial_shifter
module tb_serial_shifter;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_val;
    logic [1:0]  Mode;
    logic        Busy;
    logic        Done;
    logic [15:0] Shift_Out;
    logic        Ovfl;

    int checks   = 0;
    int failures = 0;

    serial_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Shift_In  (Shift_In),
        .Shift_val (Shift_val),
        .Mode      (Mode),
        .Busy      (Busy),
        .Done      (Done),
        .Shift_Out (Shift_Out),
        .Ovfl      (Ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_busy(input int n);
`ifdef SERSHIFT_DUAL_STEP_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    // Called at a negedge; Start is raised there so the next posedge accepts.
    // Returns at the negedge inside the Done cycle (or after a timeout).
    task automatic run_op(input string tag, input logic [15:0] din, input logic [3:0] n,
                          input logic [1:0] m, input bit poke,
                          input logic [15:0] exp_out, input logic exp_ovfl);
        int cyc;
        int busy_cyc;
        int done_cyc;
        bit both;
        Start = 1'b1; Shift_In = din; Shift_val = n; Mode = m;
        @(negedge clk);
        Start = 1'b0; Shift_In = 16'hDEAD; Shift_val = 4'd1; Mode = 2'b01;
        cyc = 1; busy_cyc = 0; done_cyc = -1; both = 1'b0;
        while (done_cyc < 0 && cyc < 40) begin
            if (Busy && Done) both = 1'b1;
            if (Busy) busy_cyc++;
            if (Done) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
                Start = poke && (cyc == 2);
            end
        end
        Start = 1'b0;
        chk({tag, "_done_cycle"}, 16'(done_cyc), 16'(exp_busy(int'(n)) + 1));
        chk({tag, "_busy_cycles"}, 16'(busy_cyc), 16'(exp_busy(int'(n))));
        chk({tag, "_busy_done_overlap"}, {15'd0, both}, 16'd0);
        chk({tag, "_out"}, Shift_Out, exp_out);
        chk({tag, "_ovfl"}, {15'd0, Ovfl}, {15'd0, exp_ovfl});
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; Start = 1'b0; Shift_In = 16'h0; Shift_val = 4'd0; Mode = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", {15'd0, Busy}, 16'd0);
        chk("reset_done", {15'd0, Done}, 16'd0);
        chk("reset_out", Shift_Out, 16'h0000);
        chk("reset_ovfl", {15'd0, Ovfl}, 16'd0);

        // Start pulsed mid-run must be dropped, not queued
        run_op("srl_poke", 16'h8001, 4'd4, 2'b00, 1'b1, 16'h0800, 1'b0);
        @(negedge clk);
        chk("srl_after_done", {14'd0, Busy, Done}, 16'd0);

        run_op("rol_n1", 16'h8001, 4'd1, 2'b10, 1'b0, 16'h0003, 1'b0);
        @(negedge clk);
        run_op("rol_n15_alias", 16'h1234, 4'd15, 2'b11, 1'b0, 16'h091A, 1'b0);
        @(negedge clk);
        run_op("sla_pos_ovf", 16'h4000, 4'd1, 2'b01, 1'b0, 16'h8000, 1'b1);
        @(negedge clk);
        run_op("sla_neg_ovf", 16'h8000, 4'd1, 2'b01, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        run_op("sla_neg_ok", 16'hFFF0, 4'd3, 2'b01, 1'b0, 16'hFF80, 1'b0);
        // Back-to-back chain: each starts in the previous op's Done cycle
        run_op("b2b_zero", 16'h1234, 4'd0, 2'b01, 1'b0, 16'h1234, 1'b0);
        run_op("b2b_sla_sticky", 16'h0C00, 4'd5, 2'b01, 1'b0, 16'h8000, 1'b1);
        run_op("b2b_sla_ok", 16'h0123, 4'd5, 2'b01, 1'b0, 16'h2460, 1'b0);
        @(negedge clk);
        chk("b2b_after_done", {14'd0, Busy, Done}, 16'd0);

        // Asynchronous reset mid-run
        Start = 1'b1; Shift_In = 16'hABCD; Shift_val = 4'd8; Mode = 2'b00;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", {15'd0, Busy}, 16'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {15'd0, Busy}, 16'd0);
        chk("rst_async_done", {15'd0, Done}, 16'd0);
        chk("rst_async_out", Shift_Out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (Done || Busy) done_seen++;
        end
        chk("rst_no_done", 16'(done_seen), 16'd0);

        run_op("srl_after_rst", 16'hFFFF, 4'd15, 2'b00, 1'b0, 16'h0001, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
